// File: rtl/shift_pkg.sv
// Shared types for the shift scheduler: op encoding for the Shift datapath
// and the scheduler FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SRL = 2'b00,
        SRA = 2'b01,
        SLL = 2'b10,
        RSV = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } sched_state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/Shift.sv
// Combinational shifter shared by the scheduler. Op 11 is reserved and yields 0;
// out-of-range shift amounts are resolved by the caller.
module Shift
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] shamt_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (shift_op_e'(sel_i))
            SRL:     data_o = a_i >> shamt_i;
            SRA:     data_o = WIDTH'($signed(a_i) >>> shamt_i);
            SLL:     data_o = a_i << shamt_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index found
// searching upward from last_grant_i + 1 with wrap-around.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            any_grant_o
);

    // Walk offsets farthest-first so the nearest requester is written last and wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(last_grant_i) + off) % NREQ;
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IW'(idx);
                any_grant_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one Shift datapath among NREQ requesters.
// Optional per-requester completion counters under SHIFT_SCHED_STATS_EN.
module shift_sched
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [2*NREQ-1:0]      req_sel_i,
    input  logic [WIDTH*NREQ-1:0]  req_a_i,
    input  logic [WIDTH*NREQ-1:0]  req_shamt_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [WIDTH-1:0]       resp_data_o,
`ifdef SHIFT_SCHED_STATS_EN
    output logic [CNT_W*NREQ-1:0]  op_count_o,
`endif
    output logic [IDW-1:0]         resp_id_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]       sel_arr   [NREQ];
    logic [WIDTH-1:0] a_arr     [NREQ];
    logic [WIDTH-1:0] shamt_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign sel_arr[gi]   = req_sel_i[2*gi +: 2];
            assign a_arr[gi]     = req_a_i[WIDTH*gi +: WIDTH];
            assign shamt_arr[gi] = req_shamt_i[WIDTH*gi +: WIDTH];
        end
    endgenerate

    sched_state_e     state_reg;
    logic [IW-1:0]    last_grant_reg;
    logic [1:0]       op_sel_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_shamt_reg;
    logic [IDW-1:0]   op_id_reg;
    logic             resp_valid_reg;
    logic [WIDTH-1:0] resp_data_reg;
    logic [IDW-1:0]   resp_id_reg;

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic             any_grant;
    logic [WIDTH-1:0] shift_out;
    logic [WIDTH-1:0] result_next;
    logic             shamt_sat;
    logic             resp_fire;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_reg),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .any_grant_o  (any_grant)
    );

    Shift #(.WIDTH(WIDTH)) u_shift (
        .sel_i   (op_sel_reg),
        .a_i     (op_a_reg),
        .shamt_i (op_shamt_reg),
        .data_o  (shift_out)
    );

    // Ready is only offered from IDLE, and is forced low while reset is held.
    assign req_ready_o  = (state_reg == IDLE && rst_ni) ? grant : '0;
    assign resp_valid_o = resp_valid_reg;
    assign resp_data_o  = resp_data_reg;
    assign resp_id_o    = resp_id_reg;
    assign resp_fire    = resp_valid_reg && resp_ready_i;

    assign shamt_sat = (op_shamt_reg >= WIDTH'(WIDTH));

    always_comb begin
        result_next = shift_out;
        if (shift_op_e'(op_sel_reg) == RSV) begin
            result_next = '0;
        end else if (shamt_sat) begin
            result_next = (shift_op_e'(op_sel_reg) == SRA) ? {WIDTH{op_a_reg[WIDTH-1]}} : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            last_grant_reg <= IW'(NREQ - 1);
            op_sel_reg     <= '0;
            op_a_reg       <= '0;
            op_shamt_reg   <= '0;
            op_id_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_id_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_grant) begin
                        op_sel_reg     <= sel_arr[grant_idx];
                        op_a_reg       <= a_arr[grant_idx];
                        op_shamt_reg   <= shamt_arr[grant_idx];
                        op_id_reg      <= IDW'(grant_idx);
                        last_grant_reg <= grant_idx;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_reg  <= result_next;
                    resp_id_reg    <= op_id_reg;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_SCHED_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= '0;
                end else if (resp_fire && resp_id_reg == IDW'(gi) && cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign op_count_o[CNT_W*gi +: CNT_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule
